// File: rtl/des_key_sched_ctrl_if.sv
// Start/key request and round-key handshake bundle for the DES key scheduler.
interface des_key_sched_ctrl_if;
  logic        start;
  logic        decrypt;
  logic [63:0] KEY;
  logic        rk_ready;
  logic        rk_valid;
  logic [47:0] rk;
  logic [3:0]  key_num;
  logic        last_key;
  logic        busy;
  logic        done;
  logic        key_err;

  modport master (
    output start, decrypt, KEY, rk_ready,
    input  rk_valid, rk, key_num, last_key, busy, done, key_err
  );
  modport slave (
    input  start, decrypt, KEY, rk_ready,
    output rk_valid, rk, key_num, last_key, busy, done, key_err
  );
endinterface

// File: rtl/des_key_sched_ctrl.sv
// Iterative DES round-key scheduler: one PC-1, one PC-2 and a rotating C/D pair,
// issuing K1..K16 (encrypt) or K16..K1 (decrypt) over a valid/ready handshake.
module des_key_sched_ctrl #(
  parameter bit CHECK_PARITY = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  des_key_sched_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_DONE} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  // Bit i set when DES shift s(i+1) is 2 rather than 1.
  localparam logic [15:0] SHIFT2 = 16'h7EFC;

  state_t      r_state;
  logic [55:0] r_pc1;
  logic        r_decrypt;
  logic [55:0] r_cd;
  logic        r_rk_valid;
  logic [47:0] r_rk;
  logic [3:0]  r_key_num;
  logic        r_last_key;
  logic        r_busy;
  logic        r_done;
  logic        r_key_err;

  logic [55:0] w_pc1;
  logic [7:0]  w_byte_odd;
  logic        w_parity_ok;
  logic [55:0] w_cd_step;
  logic [47:0] w_rk_step;
  logic [3:0]  w_key_num_step;
  logic        w_final;

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  // DES numbers bits from the MSB: DES bit n lives at vector index (width - n).
  genvar gi;
  generate
    for (gi = 0; gi < 56; gi = gi + 1) begin : g_pc1
      assign w_pc1[55-gi] = bus.KEY[64-PC1[gi]];
    end
    for (gi = 0; gi < 48; gi = gi + 1) begin : g_pc2
      assign w_rk_step[47-gi] = w_cd_step[56-PC2[gi]];
    end
    for (gi = 0; gi < 8; gi = gi + 1) begin : g_par
      assign w_byte_odd[gi] = ^bus.KEY[8*gi +: 8];
    end
  endgenerate

  assign w_parity_ok    = !CHECK_PARITY || (&w_byte_odd);
  assign w_final        = r_decrypt ? (r_key_num == 4'd0) : (r_key_num == 4'd15);
  assign w_key_num_step = r_decrypt ? (r_key_num - 4'd1) : (r_key_num + 4'd1);

  // Decrypt starts from C0/D0 unrotated because the 16 shifts total 28.
  always_comb begin
    w_cd_step = r_cd;
    if (r_state == S_LOAD) begin
      w_cd_step = r_decrypt ? r_pc1 : {rotl(r_pc1[55:28], 1'b0), rotl(r_pc1[27:0], 1'b0)};
    end else if (r_decrypt) begin
      w_cd_step = {rotr(r_cd[55:28], SHIFT2[r_key_num]), rotr(r_cd[27:0], SHIFT2[r_key_num])};
    end else begin
      w_cd_step = {rotl(r_cd[55:28], SHIFT2[w_key_num_step]),
                   rotl(r_cd[27:0], SHIFT2[w_key_num_step])};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc1      <= '0;
      r_decrypt  <= 1'b0;
      r_cd       <= '0;
      r_rk_valid <= 1'b0;
      r_rk       <= '0;
      r_key_num  <= '0;
      r_last_key <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_key_err  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_key_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_pc1     <= w_pc1;
            r_decrypt <= bus.decrypt;
            if (!w_parity_ok) begin
              r_key_err <= 1'b1;
            end else begin
              r_state <= S_LOAD;
              r_busy  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_cd       <= w_cd_step;
          r_rk       <= w_rk_step;
          r_rk_valid <= 1'b1;
          r_key_num  <= r_decrypt ? 4'd15 : 4'd0;
          r_last_key <= 1'b0;
          r_state    <= S_ROUND;
        end
        S_ROUND: begin
          if (bus.rk_ready) begin
            if (w_final) begin
              r_rk_valid <= 1'b0;
              r_rk       <= '0;
              r_key_num  <= '0;
              r_last_key <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_cd       <= w_cd_step;
              r_rk       <= w_rk_step;
              r_key_num  <= w_key_num_step;
              r_last_key <= r_decrypt ? (w_key_num_step == 4'd0) : (w_key_num_step == 4'd15);
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rk_valid = r_rk_valid;
  assign bus.rk       = r_rk;
  assign bus.key_num  = r_key_num;
  assign bus.last_key = r_last_key;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.key_err  = r_key_err;
endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Directed bench for des_key_sched_ctrl: scoreboard of reference round keys,
// latency, backpressure, restart-while-busy, mid-run reset and parity checks.
module tb_des_key_sched_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  des_key_sched_ctrl_if bus ();
  des_key_sched_ctrl_if pbus ();

  des_key_sched_ctrl #(.CHECK_PARITY(1'b0)) dut (.clk(clk), .rst(rst), .bus(bus));
  des_key_sched_ctrl #(.CHECK_PARITY(1'b1)) dut_p (.clk(clk), .rst(rst), .bus(pbus));

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
  localparam logic [47:0] K1_A  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_A = 48'hCB3D8B0E17F5;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct packed {
    logic [47:0] rk;
    logic [3:0]  num;
    logic        last;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hs_count = 0;
  int   n_done = 0;
  int   cyc = 0;

  logic        prev_stall = 1'b0;
  logic [47:0] prev_rk    = '0;
  logic [3:0]  prev_num   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Key n (1..16) straight from the definition: C0/D0 rotated left by the running total.
  function automatic logic [47:0] ref_key(input logic [63:0] key, input int n);
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] k;
    int tot;
    for (int j = 0; j < 56; j++) cd[55-j] = key[64-PC1_T[j]];
    c = cd[55:28];
    d = cd[27:0];
    tot = 0;
    for (int i = 0; i < n; i++) tot += SH_T[i];
    for (int r = 0; r < tot; r++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int j = 0; j < 48; j++) k[47-j] = cd[56-PC2_T[j]];
    return k;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [63:0] key, input logic dec);
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      int   n;
      n = dec ? 16 - i : i + 1;
      e.rk   = ref_key(key, n);
      e.num  = 4'(n - 1);
      e.last = (i == 15);
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (prev_stall)
      check("stall_hold", {bus.rk_valid, bus.rk, bus.key_num}, {1'b1, prev_rk, prev_num});
    if (!bus.rk_valid)
      check("rk_zero_idle", {bus.rk, bus.last_key}, '0);
    if (bus.rk_valid && bus.rk_ready) begin
      hs_count++;
      if (sb_q.size() == 0) begin
        check("unexpected_hs", {bus.rk_valid, bus.rk_ready}, 2'b00);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_rk", bus.rk, e.rk);
        check("sb_num_last", {bus.key_num, bus.last_key}, {e.num, e.last});
      end
    end
    if (bus.done) n_done++;
    prev_stall <= bus.rk_valid && !bus.rk_ready;
    prev_rk    <= bus.rk;
    prev_num   <= bus.key_num;
  end

  task automatic goto_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [63:0] key, input logic dec, output int c0);
    bus.start   = 1'b1;
    bus.KEY     = key;
    bus.decrypt = dec;
    c0 = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag, output int when);
    int k;
    k = 0;
    while (!bus.done && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag, bus.done, 1'b1);
    when = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int when;
    int hs0;
    int d0;
    int k;

    rst = 1'b1;
    bus.start = 1'b0;  bus.decrypt = 1'b0;  bus.KEY = '0;  bus.rk_ready = 1'b1;
    pbus.start = 1'b0; pbus.decrypt = 1'b0; pbus.KEY = '0; pbus.rk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.rk_valid, bus.rk, bus.key_num, bus.last_key,
                            bus.busy, bus.done, bus.key_err}, '0);
    check("reset_outputs_p", {pbus.rk_valid, pbus.rk, pbus.busy, pbus.key_err}, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Encrypt with ready held high: exact latency and known K1/K16.
    hs0 = hs_count;
    push_seq(KEY_A, 1'b0);
    do_start(KEY_A, 1'b0, c0);
    check("enc_load_cycle", {bus.busy, bus.rk_valid}, 2'b10);
    goto_cyc(c0 + 2);
    check("enc_first_rk", {bus.rk_valid, bus.rk, bus.key_num}, {1'b1, K1_A, 4'h0});
    goto_cyc(c0 + 17);
    check("enc_last_rk", {bus.rk_valid, bus.rk, bus.key_num, bus.last_key},
          {1'b1, K16_A, 4'hF, 1'b1});
    goto_cyc(c0 + 18);
    check("enc_done_cycle", {bus.done, bus.busy, bus.rk_valid}, 3'b110);
    goto_cyc(c0 + 19);
    check("enc_idle_cycle", {bus.done, bus.busy}, 2'b00);
    check("enc_hs_count", hs_count - hs0, 16);

    // Decrypt: reverse order, scoreboard holds the reference sequence.
    hs0 = hs_count;
    push_seq(KEY_A, 1'b1);
    do_start(KEY_A, 1'b1, c0);
    goto_cyc(c0 + 2);
    check("dec_first_rk", {bus.rk, bus.key_num}, {K16_A, 4'hF});
    goto_cyc(c0 + 17);
    check("dec_last_rk", {bus.rk, bus.key_num, bus.last_key}, {K1_A, 4'h0, 1'b1});
    wait_done(10, "dec_done", when);
    check("dec_done_cycle", when, c0 + 18);
    check("dec_hs_count", hs_count - hs0, 16);
    @(posedge clk);
    #1;

    // Backpressure with ~30% ready duty.
    hs0 = hs_count;
    d0 = n_done;
    bus.rk_ready = 1'b0;
    push_seq(KEY_B, 1'b0);
    do_start(KEY_B, 1'b0, c0);
    k = 0;
    while (!bus.done && k < 600) begin
      bus.rk_ready = ($urandom_range(0, 9) < 3);
      @(posedge clk);
      #1;
      k++;
    end
    check("bp_done", bus.done, 1'b1);
    check("bp_hs_count", hs_count - hs0, 16);
    bus.rk_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_done_pulses", n_done - d0, 1);

    // start with a different key/direction while busy at key 5 is ignored.
    push_seq(KEY_A, 1'b0);
    do_start(KEY_A, 1'b0, c0);
    goto_cyc(c0 + 6);
    check("restart_at_key5", bus.key_num, 4'd4);
    bus.start = 1'b1; bus.KEY = KEY_B; bus.decrypt = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(20, "restart_done", when);
    check("restart_done_cycle", when, c0 + 18);
    check("restart_sb_empty", sb_q.size(), 0);
    @(posedge clk);
    #1;
    push_seq(KEY_B, 1'b0);
    do_start(KEY_B, 1'b0, c0);
    wait_done(30, "newkey_done", when);
    check("newkey_sb_empty", sb_q.size(), 0);
    @(posedge clk);
    #1;

    // Reset during key 9: outputs clear, no done pulse, then a clean run.
    push_seq(KEY_A, 1'b0);
    do_start(KEY_A, 1'b0, c0);
    goto_cyc(c0 + 10);
    check("rst_at_key9", bus.key_num, 4'd8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_outputs", {bus.rk_valid, bus.rk, bus.key_num, bus.last_key,
                              bus.busy, bus.done, bus.key_err}, '0);
    d0 = n_done;
    sb_q.delete();
    repeat (20) @(posedge clk);
    #1;
    check("rst_no_done", n_done - d0, 0);
    hs0 = hs_count;
    push_seq(KEY_B, 1'b1);
    do_start(KEY_B, 1'b1, c0);
    wait_done(30, "post_rst_done", when);
    check("post_rst_done_cycle", when, c0 + 18);
    check("post_rst_hs", hs_count - hs0, 16);
    @(posedge clk);
    #1;

    // Parity checking instance: all-zero key is rejected.
    pbus.start = 1'b1; pbus.KEY = 64'h0; pbus.decrypt = 1'b0;
    c0 = cyc;
    @(posedge clk);
    #1;
    pbus.start = 1'b0;
    check("par_err_pulse", {pbus.key_err, pbus.busy, pbus.rk_valid}, 3'b100);
    @(posedge clk);
    #1;
    check("par_err_after", {pbus.key_err, pbus.busy, pbus.rk_valid}, 3'b000);
    @(posedge clk);
    #1;

    // Parity checking instance: odd-parity key runs normally.
    pbus.start = 1'b1; pbus.KEY = KEY_A; pbus.decrypt = 1'b0;
    c0 = cyc;
    @(posedge clk);
    #1;
    pbus.start = 1'b0;
    check("par_ok_no_err", pbus.key_err, 1'b0);
    for (int i = 0; i < 16; i++) begin
      goto_cyc(c0 + 2 + i);
      check("par_ok_rk", {pbus.rk_valid, pbus.rk, pbus.key_num},
            {1'b1, ref_key(KEY_A, i + 1), 4'(i)});
    end
    goto_cyc(c0 + 18);
    check("par_ok_done", {pbus.done, pbus.rk_valid}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
